// File: rtl/leaf_out_arbiter.sv
// Merges NUM_OUT_PORTS user streams onto one BFT packet port: 2-deep FIFO per port,
// round-robin arbitration, per-port address sequencing. Define LEAF_OUT_CREDIT_EN for credit gating.
module leaf_out_arbiter #(
   parameter int unsigned NUM_OUT_PORTS = 4,
   parameter int unsigned PAYLOAD_BITS  = 32,
   parameter int unsigned NUM_LEAF_BITS = 5,
   parameter int unsigned NUM_PORT_BITS = 4,
   parameter int unsigned NUM_ADDR_BITS = 7,
   parameter int unsigned CREDIT_BITS   = 8,
   parameter int unsigned CREDIT_INIT   = 64,
   localparam int unsigned PACKET_BITS  = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
   input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
   output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
   input  logic                                  cfg_we,
   input  logic [NUM_PORT_BITS-1:0]              cfg_port,
   input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
   input  logic [NUM_PORT_BITS-1:0]              cfg_dport,
   input  logic                                  credit_vld,
   input  logic [NUM_PORT_BITS-1:0]              credit_port,
   input  logic [CREDIT_BITS-1:0]                credit_amt,
   input  logic                                  resend,
   output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft
);

   localparam int unsigned PTR_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

   typedef struct packed {
      logic                     vld;
      logic [NUM_LEAF_BITS-1:0] leaf;
      logic [NUM_PORT_BITS-1:0] port;
      logic [NUM_ADDR_BITS-1:0] addr;
      logic [PAYLOAD_BITS-1:0]  payload;
   } packet_t;

   logic [PAYLOAD_BITS-1:0]  fifo_mem [NUM_OUT_PORTS][2];
   logic [1:0]               cnt      [NUM_OUT_PORTS];
   logic [NUM_OUT_PORTS-1:0] rd_ptr;
   logic [NUM_OUT_PORTS-1:0] push;
   logic [NUM_OUT_PORTS-1:0] pop;
   logic [NUM_OUT_PORTS-1:0] nonempty;
   logic [NUM_OUT_PORTS-1:0] credit_ok;
   logic [NUM_OUT_PORTS-1:0] eligible;

   logic [NUM_LEAF_BITS-1:0] dest_leaf [NUM_OUT_PORTS];
   logic [NUM_PORT_BITS-1:0] dest_port [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] addr      [NUM_OUT_PORTS];

   logic                     grant_vld;
   logic [PTR_BITS-1:0]      grant_idx;
   logic [PTR_BITS-1:0]      last_grant;
   packet_t                  grant_pkt;
   packet_t                  dout_q;

   // FIFO handshake: ready depends on occupancy only
   always_comb begin
      ack_interface2user = '0;
      push               = '0;
      pop                = '0;
      nonempty           = '0;
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
         ack_interface2user[i] = cnt[i] < 2'd2;
         push[i]               = vld_user2interface[i] && ack_interface2user[i];
         pop[i]                = grant_vld && (grant_idx == PTR_BITS'(i));
         nonempty[i]           = cnt[i] != 2'd0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) cnt[i] <= 2'd0;
      end else begin
         for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            cnt[i]    <= cnt[i] + 2'(push[i]) - 2'(pop[i]);
            rd_ptr[i] <= rd_ptr[i] ^ pop[i];
         end
      end
   end

   // Storage needs no reset; occupancy alone defines validity
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
         if (push[i]) fifo_mem[i][rd_ptr[i] ^ cnt[i][0]] <= din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
   end

`ifdef LEAF_OUT_CREDIT_EN
   logic [CREDIT_BITS-1:0] credit     [NUM_OUT_PORTS];
   logic [CREDIT_BITS:0]   credit_sum [NUM_OUT_PORTS];

   always_comb begin
      credit_ok = '0;
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) credit_ok[i] = credit[i] != '0;
   end

   // Spend-then-return with saturation; a granted port always holds at least one credit
   always_comb begin
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
         credit_sum[i] = {1'b0, credit[i]} - (CREDIT_BITS+1)'(pop[i]);
         if (credit_vld && (32'(credit_port) == i)) credit_sum[i] = credit_sum[i] + {1'b0, credit_amt};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) credit[i] <= CREDIT_BITS'(CREDIT_INIT);
      end else begin
         for (int unsigned i = 0; i < NUM_OUT_PORTS; i++)
            credit[i] <= credit_sum[i][CREDIT_BITS] ? '1 : credit_sum[i][CREDIT_BITS-1:0];
      end
   end
`else
   logic unused_credit;
   assign unused_credit = ^{credit_vld, credit_port, credit_amt, CREDIT_BITS'(CREDIT_INIT)};
   assign credit_ok     = '1;
`endif

   assign eligible = nonempty & credit_ok & {NUM_OUT_PORTS{~resend}};

   // Round-robin: first eligible port strictly after the last grant
   always_comb begin
      logic [PTR_BITS-1:0] sel;
      sel       = '0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int unsigned k = 1; k <= NUM_OUT_PORTS; k++) begin
         sel = PTR_BITS'((32'(last_grant) + k) % NUM_OUT_PORTS);
         if (!grant_vld && eligible[sel]) begin
            grant_vld = 1'b1;
            grant_idx = sel;
         end
      end
   end

   always_comb begin
      grant_pkt = '0;
      if (grant_vld) begin
         grant_pkt.vld     = 1'b1;
         grant_pkt.leaf    = dest_leaf[grant_idx];
         grant_pkt.port    = dest_port[grant_idx];
         grant_pkt.addr    = addr[grant_idx];
         grant_pkt.payload = fifo_mem[grant_idx][rd_ptr[grant_idx]];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= PTR_BITS'(NUM_OUT_PORTS - 1);
         dout_q     <= '0;
         for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            addr[i]      <= '0;
            dest_leaf[i] <= '0;
            dest_port[i] <= NUM_PORT_BITS'(i);
         end
      end else begin
         if (grant_vld) begin
            last_grant      <= grant_idx;
            addr[grant_idx] <= addr[grant_idx] + NUM_ADDR_BITS'(1);
         end
         for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            if (cfg_we && (32'(cfg_port) == i)) begin
               dest_leaf[i] <= cfg_leaf;
               dest_port[i] <= cfg_dport;
            end
         end
         // Hold the pending packet through resend so it reaches the BFT once resend drops
         if (!resend) dout_q <= grant_pkt;
      end
   end

   assign dout_leaf_interface2bft = resend ? '0 : dout_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Self-checking bench for leaf_out_arbiter: randomized and directed stimulus against
// a queue-based transaction model of the arbiter (honours LEAF_OUT_CREDIT_EN).
module tb_leaf_out_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned PB  = 32;
   localparam int unsigned LB  = 5;
   localparam int unsigned PTB = 4;
   localparam int unsigned AB  = 7;
   localparam int unsigned CB  = 8;
   localparam int unsigned CI  = 2;
   localparam int unsigned PKB = 1 + LB + PTB + AB + PB;
`ifdef LEAF_OUT_CREDIT_EN
   localparam bit CRED_EN = 1'b1;
`else
   localparam bit CRED_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset_n = 1'b1;
   logic [N*PB-1:0] din;
   logic [N-1:0]   vld;
   logic [N-1:0]   ack;
   logic           cfg_we;
   logic [PTB-1:0] cfg_port;
   logic [LB-1:0]  cfg_leaf;
   logic [PTB-1:0] cfg_dport;
   logic           credit_vld;
   logic [PTB-1:0] credit_port;
   logic [CB-1:0]  credit_amt;
   logic           resend;
   logic [PKB-1:0] dout;

   leaf_out_arbiter #(
      .NUM_OUT_PORTS(N), .PAYLOAD_BITS(PB), .NUM_LEAF_BITS(LB), .NUM_PORT_BITS(PTB),
      .NUM_ADDR_BITS(AB), .CREDIT_BITS(CB), .CREDIT_INIT(CI)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .din_leaf_user2interface(din), .vld_user2interface(vld), .ack_interface2user(ack),
      .cfg_we(cfg_we), .cfg_port(cfg_port), .cfg_leaf(cfg_leaf), .cfg_dport(cfg_dport),
      .credit_vld(credit_vld), .credit_port(credit_port), .credit_amt(credit_amt),
      .resend(resend), .dout_leaf_interface2bft(dout)
   );

   always #5 clk = ~clk;

   // Reference model: per-port word queues plus per-port tables
   typedef logic [PB-1:0] pay_q_t [$];
   pay_q_t         m_q [N];
   int             m_credit [N];
   int             m_addr   [N];
   int             m_leaf   [N];
   int             m_dport  [N];
   int             m_last;
   int             m_pushes;
   logic [PKB-1:0] m_reg;

   int checks = 0;
   int errors = 0;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_q[i].delete();
         m_credit[i] = CI;
         m_addr[i]   = 0;
         m_leaf[i]   = 0;
         m_dport[i]  = i;
      end
      m_last = N - 1;
      m_reg  = '0;
   endfunction

   // Effect of one rising edge given the inputs currently driven
   function automatic void model_edge();
      bit [N-1:0] ackp;
      int g;
      logic [PB-1:0] w;
      for (int i = 0; i < N; i++) ackp[i] = m_q[i].size() < 2;
      if (!resend) begin
         g = -1;
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (g < 0 && m_q[j].size() > 0 && (!CRED_EN || m_credit[j] > 0)) g = j;
         end
         if (g >= 0) begin
            w = m_q[g].pop_front();
            m_reg = {1'b1, LB'(m_leaf[g]), PTB'(m_dport[g]), AB'(m_addr[g]), w};
            m_addr[g] = (m_addr[g] + 1) % (1 << AB);
            m_credit[g]--;
            m_last = g;
         end else begin
            m_reg = '0;
         end
      end
      if (credit_vld && credit_port < N) begin
         m_credit[credit_port] += int'(credit_amt);
         if (m_credit[credit_port] > (1 << CB) - 1) m_credit[credit_port] = (1 << CB) - 1;
      end
      if (cfg_we && cfg_port < N) begin
         m_leaf[cfg_port]  = int'(cfg_leaf);
         m_dport[cfg_port] = int'(cfg_dport);
      end
      for (int i = 0; i < N; i++) begin
         if (vld[i] && ackp[i]) begin
            m_q[i].push_back(din[i*PB +: PB]);
            m_pushes++;
         end
      end
   endfunction

   function automatic logic [PKB-1:0] exp_dout();
      return resend ? '0 : m_reg;
   endfunction

   function automatic logic [N-1:0] exp_ack();
      logic [N-1:0] a;
      for (int i = 0; i < N; i++) a[i] = m_q[i].size() < 2;
      return a;
   endfunction

   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_idle();
      din = '0; vld = '0; cfg_we = 1'b0; cfg_port = '0; cfg_leaf = '0; cfg_dport = '0;
      credit_vld = 1'b0; credit_port = '0; credit_amt = '0; resend = 1'b0;
   endtask

   task automatic do_reset();
      set_idle();
      #2 reset_n = 1'b0;
      @(negedge clk);
      model_reset();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      set_idle();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
      checks++; if (ack !== 4'hF) begin errors++; $display("FAIL reset_ack got %b want 1111", ack); end
      model_reset();
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      logic [PKB-1:0] want;
      din[2*PB +: PB] = 32'hDEADBEEF;
      vld = 4'b0100;
      step();
      vld = '0;
      checks++; if (dout !== '0) begin errors++; $display("FAIL single_early got %h want 0", dout); end
      step();
      want = {1'b1, 5'd0, 4'd2, 7'd0, 32'hDEADBEEF};
      checks++; if (dout !== want) begin errors++; $display("FAIL single_pkt got %h want %h", dout, want); end
      step();
      checks++; if (dout !== '0) begin errors++; $display("FAIL single_once got %h want 0", dout); end
   endtask

   task automatic test_round_robin();
      int prev = -1;
      int npk = 0;
      int p;
      for (int c = 0; c < 32; c++) begin
         vld = '1;
         for (int i = 0; i < N; i++) din[i*PB +: PB] = $urandom();
         credit_vld = 1'b1; credit_port = PTB'(c % N); credit_amt = 8'd3;
         step();
         checks++; if (dout !== exp_dout()) begin errors++; $display("FAIL rr_dout cyc %0d got %h want %h", c, dout, exp_dout()); end
         checks++; if (ack !== exp_ack()) begin errors++; $display("FAIL rr_ack cyc %0d got %b want %b", c, ack, exp_ack()); end
         if (dout[PKB-1]) begin
            p = int'(dout[PB+AB +: PTB]);
            if (prev >= 0) begin
               checks++; if (p != (prev + 1) % N) begin errors++; $display("FAIL rr_order got %0d want %0d", p, (prev + 1) % N); end
            end
            prev = p;
            npk++;
         end
      end
      checks++; if (npk != 31) begin errors++; $display("FAIL rr_rate got %0d want 31", npk); end
      vld = '0;
      for (int c = 0; c < 12; c++) begin
         credit_port = PTB'(c % N);
         step();
         checks++; if (dout !== exp_dout()) begin errors++; $display("FAIL rr_drain got %h want %h", dout, exp_dout()); end
      end
      credit_vld = 1'b0;
   endtask

   task automatic test_resend();
      int next_addr [N];
      int start_push = m_pushes;
      int npk = 0;
      int p;
      for (int i = 0; i < N; i++) next_addr[i] = m_addr[i];
      for (int c = 0; c < 28; c++) begin
         vld = (c < 12) ? '1 : '0;
         for (int i = 0; i < N; i++) din[i*PB +: PB] = $urandom();
         resend = (c >= 5 && c <= 7);
         credit_vld = 1'b1; credit_port = PTB'(c % N); credit_amt = 8'd3;
         step();
         checks++; if (dout !== exp_dout()) begin errors++; $display("FAIL rs_dout cyc %0d got %h want %h", c, dout, exp_dout()); end
         if (resend) begin
            checks++; if (dout !== '0) begin errors++; $display("FAIL rs_blank cyc %0d got %h want 0", c, dout); end
         end
         if (dout[PKB-1]) begin
            p = int'(dout[PB+AB +: PTB]);
            checks++;
            if (int'(dout[PB +: AB]) != next_addr[p]) begin
               errors++; $display("FAIL rs_addr port %0d got %0d want %0d", p, dout[PB +: AB], next_addr[p]);
            end
            next_addr[p] = (next_addr[p] + 1) % (1 << AB);
            npk++;
         end
      end
      set_idle();
      checks++; if (npk != m_pushes - start_push) begin errors++; $display("FAIL rs_count got %0d want %0d", npk, m_pushes - start_push); end
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 3; c++) begin
         vld = '1;
         for (int i = 0; i < N; i++) din[i*PB +: PB] = $urandom();
         step();
      end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (dout !== '0) begin errors++; $display("FAIL rstmid_dout got %h want 0", dout); end
      checks++; if (ack !== 4'hF) begin errors++; $display("FAIL rstmid_ack got %b want 1111", ack); end
      set_idle();
      @(negedge clk);
      model_reset();
      reset_n = 1'b1;
      step();
      checks++; if (dout !== '0) begin errors++; $display("FAIL rstmid_flush got %h want 0", dout); end
   endtask

   task automatic test_addr_wrap();
      int start_push = m_pushes;
      int npk = 0;
      credit_vld = 1'b1; credit_port = '0; credit_amt = 8'd1;
      for (int c = 0; c < 200 && npk < 130; c++) begin
         vld = (m_pushes - start_push < 130) ? 4'b0001 : 4'b0000;
         din[PB-1:0] = $urandom();
         step();
         checks++; if (dout !== exp_dout()) begin errors++; $display("FAIL wrap_dout cyc %0d got %h want %h", c, dout, exp_dout()); end
         if (dout[PKB-1]) begin
            checks++;
            if (dout[PB +: AB] !== AB'(npk % 128) || dout[PB+AB +: PTB] !== 4'd0) begin
               errors++; $display("FAIL wrap_addr pkt %0d got %0d want %0d", npk, dout[PB +: AB], npk % 128);
            end
            npk++;
         end
      end
      checks++; if (npk != 130) begin errors++; $display("FAIL wrap_count got %0d want 130", npk); end
      set_idle();
   endtask

   task automatic test_cfg();
      logic [PB-1:0] w0, w1;
      w0 = $urandom(); w1 = $urandom();
      vld = 4'b1000; din[3*PB +: PB] = w0;
      step();
      checks++; if (dout !== '0) begin errors++; $display("FAIL cfg_idle got %h want 0", dout); end
      din[3*PB +: PB] = w1;
      cfg_we = 1'b1; cfg_port = 4'd3; cfg_leaf = 5'd17; cfg_dport = 4'd9;
      step();
      set_idle();
      checks++;
      if (dout !== {1'b1, 5'd0, 4'd3, 7'd0, w0}) begin
         errors++; $display("FAIL cfg_old got %h want %h", dout, {1'b1, 5'd0, 4'd3, 7'd0, w0});
      end
      step();
      checks++;
      if (dout !== {1'b1, 5'd17, 4'd9, 7'd1, w1}) begin
         errors++; $display("FAIL cfg_new got %h want %h", dout, {1'b1, 5'd17, 4'd9, 7'd1, w1});
      end
      checks++; if (dout !== exp_dout()) begin errors++; $display("FAIL cfg_model got %h want %h", dout, exp_dout()); end
   endtask

   task automatic test_credit();
      logic [PB-1:0] words [5];
      int start_push;
      int npk = 0;
      do_reset();
      start_push = m_pushes;
      for (int i = 0; i < 5; i++) words[i] = $urandom();
      for (int c = 0; c < 26; c++) begin
         vld = (m_pushes - start_push < 5) ? 4'b0010 : 4'b0000;
         din[PB +: PB] = words[(m_pushes - start_push < 5) ? m_pushes - start_push : 0];
         credit_vld = (c == 14); credit_port = 4'd1; credit_amt = 8'd3;
         step();
         checks++; if (dout !== exp_dout()) begin errors++; $display("FAIL cr_dout cyc %0d got %h want %h", c, dout, exp_dout()); end
         if (dout[PKB-1]) begin
            checks++;
            if (dout[PB-1:0] !== words[npk] || dout[PB+AB +: PTB] !== 4'd1) begin
               errors++; $display("FAIL cr_word pkt %0d got %h want %h", npk, dout[PB-1:0], words[npk]);
            end
            npk++;
         end
         if (c == 13) begin
            checks++;
            if (npk != (CRED_EN ? 2 : 5)) begin errors++; $display("FAIL cr_stall got %0d want %0d", npk, CRED_EN ? 2 : 5); end
         end
      end
      set_idle();
      checks++; if (npk != 5) begin errors++; $display("FAIL cr_total got %0d want 5", npk); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         vld = N'($urandom());
         for (int i = 0; i < N; i++) din[i*PB +: PB] = $urandom();
         resend      = ($urandom_range(0, 9) == 0);
         credit_vld  = ($urandom_range(0, 2) == 0);
         credit_port = PTB'($urandom_range(0, 15));
         credit_amt  = CB'($urandom_range(0, 255));
         cfg_we      = ($urandom_range(0, 15) == 0);
         cfg_port    = PTB'($urandom_range(0, 15));
         cfg_leaf    = LB'($urandom());
         cfg_dport   = PTB'($urandom());
         step();
         checks++; if (dout !== exp_dout()) begin errors++; $display("FAIL rnd_dout cyc %0d got %h want %h", c, dout, exp_dout()); end
         checks++; if (ack !== exp_ack()) begin errors++; $display("FAIL rnd_ack cyc %0d got %b want %b", c, ack, exp_ack()); end
      end
      set_idle();
      credit_vld = 1'b1; credit_amt = 8'd4;
      for (int c = 0; c < 16; c++) begin
         credit_port = PTB'(c % N);
         step();
         checks++; if (dout !== exp_dout()) begin errors++; $display("FAIL rnd_drain got %h want %h", dout, exp_dout()); end
      end
      set_idle();
      checks++; if (ack !== 4'hF) begin errors++; $display("FAIL rnd_empty got %b want 1111", ack); end
   endtask

   initial begin
      m_pushes = 0;
      set_idle();
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_resend();
      test_reset_mid();
      test_addr_wrap();
      test_cfg();
      test_credit();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
